axil_req_arbiter: RTL and testbench
===================================

AXIL_REQ_ARBITER -- requirements
Module: axil_req_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, byte address width on the master port, covering four 32-bit registers.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed data width; WSTRB width SHALL be DATA_WIDTH/8.
REQ-003 ACLK  in  1  the single clock; all logic on its rising edge.
REQ-004 ARESETN  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  2  per-requester command valid; bit i belongs to requester i.
REQ-006 req_ready  out  2  per-requester command accept, one-hot or zero.
REQ-007 req_write  in  2  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  in  2*ADDR_WIDTH  per-requester address; requester i occupies slice i.
REQ-009 req_wdata  in  2*DATA_WIDTH  per-requester write data; requester i occupies slice i.
REQ-010 rsp_valid  out  2  per-requester one-cycle completion pulse, one-hot or zero.
REQ-011 rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid.
REQ-012 rsp_resp  out  2  AXI response code, valid with rsp_valid.
REQ-013 M_AXI_AW*/W*/B*/AR*/R*  mixed  AXI4-Lite master channels: AWADDR, AWPROT(3), AWVALID, AWREADY; WDATA, WSTRB, WVALID, WREADY; BRESP, BVALID, BREADY; ARADDR, ARPROT(3), ARVALID, ARREADY; RDATA, RRESP, RVALID, RREADY.

Function
REQ-014 SHALL sequence one transaction at a time with FSM states IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-015 IDLE: if any req_valid is high, SHALL grant one requester, assert its req_ready for exactly that cycle, latch write/addr/wdata and grant index, and move to WR or RD_ADDR.
REQ-016 Arbitration SHALL be round-robin: with both requesting, grant the requester not granted last; the last-grant register resets to 1, so requester 0 wins the first tie.
REQ-017 A single requester SHALL be granted regardless of last-grant.
REQ-018 WR: AWVALID and WVALID SHALL rise the cycle after accept; each SHALL drop independently on its own handshake; the FSM SHALL move to WR_RESP once both have handshaken, same-cycle or in either order.
REQ-019 WSTRB SHALL be all ones; AWPROT and ARPROT SHALL be 0.
REQ-020 WR_RESP: BREADY SHALL be high; on BVALID, SHALL latch BRESP, set rsp_rdata to 0, and go to DONE.
REQ-021 RD_ADDR: ARVALID SHALL be high until ARREADY, then go to RD_DATA.
REQ-022 RD_DATA: RREADY SHALL be high; on RVALID, SHALL latch RDATA and RRESP and go to DONE.
REQ-023 DONE: SHALL pulse rsp_valid[grant] for one cycle with latched rdata/resp, then return to IDLE; no new grant SHALL occur in DONE.
REQ-024 Minimum turnaround for a zero-wait slave: accept at cycle 0, master valid at cycle 1, response handshake at cycle 2, rsp_valid at cycle 3, next grant possible at cycle 4.
REQ-025 Master VALID signals SHALL not drop before their READY and SHALL be registered outputs.
REQ-026 Latched address and data SHALL hold stable from accept until DONE, independent of req_* changes.
REQ-027 Non-OKAY responses (SLVERR/DECERR) SHALL pass through to rsp_resp unchanged; no retry.

Reset
REQ-028 With ARESETN low, SHALL force: state IDLE; all master VALID/READY outputs 0; req_ready 0; rsp_valid 0; rsp_rdata 0; rsp_resp 0; last-grant 1.
REQ-029 Reset asserted mid-transaction SHALL abort it immediately with no rsp_valid issued; after release the FSM SHALL start from IDLE.

Verification
REQ-030 Req0 writes 0x00000001 to addr 0x0, then reads addr 0x0 -> one AW/W pair with WDATA=0x1, WSTRB=0xF, then rsp_valid[0] with rsp_rdata=0x00000001, rsp_resp=0.
REQ-031 Both requesters assert reads (req0 addr 0x4, req1 addr 0x8) and hold them -> grant order 0,1,0,1; ARADDR sequence 0x4, 0x8, 0x4, 0x8.
REQ-032 Slave delays WREADY 3 cycles after AWREADY on a write to 0xC -> AWVALID drops after 1 cycle, WVALID holds 4 cycles, exactly one rsp_valid.
REQ-033 Zero-wait slave, back-to-back writes from req1 -> req_ready[1] pulses 4 cycles apart, per REQ-024.
REQ-034 Slave returns RRESP=2'b10 on read of 0x4 -> rsp_resp=2'b10 and rsp_rdata=RDATA.
REQ-035 ARESETN driven low while in RD_DATA -> RREADY and ARVALID are 0 immediately, no rsp_valid, and the next request is granted normally after release.

Source files
------------

// File: rtl/axil_req_arbiter.sv
// axil_req_arbiter: round-robin arbiter for two requesters sharing one AXI4-Lite master,
// running a single transaction at a time from accept through completion pulse.
module axil_req_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [1:0]                req_valid,
    output logic [1:0]                req_ready,
    input  logic [1:0]                req_write,
    input  logic [2*ADDR_WIDTH-1:0]   req_addr,
    input  logic [2*DATA_WIDTH-1:0]   req_wdata,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);
    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE} state_t;
    state_t state;
    logic last_grant, grant, gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    // On a tie the requester not served last wins; a lone requester always wins
    assign gnt = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    assign req_ready = (ARESETN && state == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign M_AXI_AWADDR = addr;
    assign M_AXI_ARADDR = addr;
    assign M_AXI_WDATA = wdata;
    assign M_AXI_WSTRB = '1;
    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state <= IDLE;
            last_grant <= 1'b1;
            grant <= 1'b0;
            addr <= '0;
            wdata <= '0;
            M_AXI_AWVALID <= 1'b0;
            M_AXI_WVALID <= 1'b0;
            M_AXI_BREADY <= 1'b0;
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_rdata <= '0;
            rsp_resp <= 2'b00;
        end else begin
            case (state)
                IDLE: if (|req_valid) begin
                    grant <= gnt;
                    last_grant <= gnt;
                    addr <= gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                    wdata <= gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                    if (req_write[gnt]) begin
                        M_AXI_AWVALID <= 1'b1;
                        M_AXI_WVALID <= 1'b1;
                        state <= WR;
                    end else begin
                        M_AXI_ARVALID <= 1'b1;
                        state <= RD_ADDR;
                    end
                end
                WR: begin
                    if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
                    if (M_AXI_WREADY) M_AXI_WVALID <= 1'b0;
                    // Each channel is finished once it has dropped or is handshaking now
                    if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
                        M_AXI_BREADY <= 1'b1;
                        state <= WR_RESP;
                    end
                end
                WR_RESP: if (M_AXI_BVALID) begin
                    M_AXI_BREADY <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_resp <= M_AXI_BRESP;
                    rsp_valid <= grant ? 2'b10 : 2'b01;
                    state <= DONE;
                end
                RD_ADDR: if (M_AXI_ARREADY) begin
                    M_AXI_ARVALID <= 1'b0;
                    M_AXI_RREADY <= 1'b1;
                    state <= RD_DATA;
                end
                RD_DATA: if (M_AXI_RVALID) begin
                    M_AXI_RREADY <= 1'b0;
                    rsp_rdata <= M_AXI_RDATA;
                    rsp_resp <= M_AXI_RRESP;
                    rsp_valid <= grant ? 2'b10 : 2'b01;
                    state <= DONE;
                end
                DONE: begin
                    rsp_valid <= 2'b00;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_req_arbiter.sv
// tb_axil_req_arbiter: directed bench with a behavioural AXI4-Lite slave and a response scoreboard.
module tb_axil_req_arbiter;
    typedef struct {int idx; logic [31:0] rdata; logic [1:0] resp;} exp_t;
    logic ACLK = 1'b0;
    logic ARESETN = 1'b1;
    logic [1:0] req_valid, req_ready, req_write, rsp_valid, rsp_resp;
    logic [7:0] req_addr;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata;
    logic [3:0] awaddr, araddr, wstrb;
    logic [2:0] awprot, arprot;
    logic [31:0] wdata, rdata;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int aw_cyc = 0;
    int w_cyc = 0;
    int grant_log[$];
    int acc_cyc1[$];
    logic [3:0] aw_log[$];
    logic [3:0] ar_log[$];
    logic [35:0] w_log[$];
    exp_t sb[$];
    logic [31:0] ref_mem [4] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
    logic [31:0] mem [4] = '{32'h1111_0000, 32'h2222_0004, 32'h3333_0008, 32'h4444_000C};
    int w_delay = 0;
    int wcnt;
    logic r_stall = 1'b0;
    logic rerr = 1'b0;
    logic r_pend, got_aw, got_w;
    logic [3:0] s_awaddr;
    logic [31:0] s_wdata, rdata_r;
    logic [1:0] rresp_r;

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    axil_req_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    // Slave: AW/AR always ready, WREADY held off w_delay cycles, R optionally stalled
    assign awready = 1'b1;
    assign arready = 1'b1;
    assign wready = wvalid && (wcnt >= w_delay);
    assign bresp = 2'b00;
    assign rdata = rdata_r;
    assign rresp = rresp_r;

    always @(posedge ACLK or negedge ARESETN) begin
        logic aw_hs, w_hs;
        logic [3:0] wa;
        if (!ARESETN) begin
            bvalid <= 1'b0;
            rvalid <= 1'b0;
            got_aw <= 1'b0;
            got_w <= 1'b0;
            wcnt <= 0;
            r_pend <= 1'b0;
        end else begin
            aw_hs = awvalid && awready;
            w_hs = wvalid && wready;
            wa = aw_hs ? awaddr : s_awaddr;
            if (aw_hs) s_awaddr <= awaddr;
            if (w_hs) s_wdata <= wdata;
            wcnt <= w_hs ? 0 : (wvalid ? wcnt + 1 : wcnt);
            if (bvalid && bready) bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                mem[wa[3:2]] <= w_hs ? wdata : s_wdata;
                bvalid <= 1'b1;
                got_aw <= 1'b0;
                got_w <= 1'b0;
            end else begin
                if (aw_hs) got_aw <= 1'b1;
                if (w_hs) got_w <= 1'b1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
            if (arvalid && arready) begin
                rdata_r <= mem[araddr[3:2]];
                rresp_r <= rerr ? 2'b10 : 2'b00;
                if (r_stall) r_pend <= 1'b1;
                else rvalid <= 1'b1;
            end else if (r_pend && !r_stall) begin
                r_pend <= 1'b0;
                rvalid <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: accepts push expectations, completions pop and compare
    always @(negedge ACLK) begin
        int i;
        logic [3:0] a;
        exp_t e;
        #2;
        if (|(req_valid & req_ready)) begin
            i = req_ready[1] ? 1 : 0;
            a = i ? req_addr[7:4] : req_addr[3:0];
            grant_log.push_back(i);
            if (i == 1) acc_cyc1.push_back(cyc);
            if (req_write[i]) begin
                ref_mem[a[3:2]] = i ? req_wdata[63:32] : req_wdata[31:0];
                sb.push_back('{idx: i, rdata: 32'h0, resp: 2'b00});
            end else begin
                sb.push_back('{idx: i, rdata: ref_mem[a[3:2]], resp: rerr ? 2'b10 : 2'b00});
            end
        end
        if (awvalid) aw_cyc++;
        if (wvalid) w_cyc++;
        if (awvalid && awready) begin
            aw_log.push_back(awaddr);
            chk("awprot", awprot, 0);
        end
        if (wvalid && wready) w_log.push_back({wstrb, wdata});
        if (arvalid && arready) begin
            ar_log.push_back(araddr);
            chk("arprot", arprot, 0);
        end
        if (|rsp_valid) begin
            rsp_cnt++;
            if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
                e = sb.pop_front();
                chk("rsp_valid", rsp_valid, e.idx ? 2'b10 : 2'b01);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_resp", rsp_resp, e.resp);
            end
        end
    end

    task automatic req(input int i, input logic w, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        req_valid[i] = 1'b1;
        req_write[i] = w;
        if (i == 1) begin
            req_addr[7:4] = a;
            req_wdata[63:32] = d;
        end else begin
            req_addr[3:0] = a;
            req_wdata[31:0] = d;
        end
        #1;
        while (!req_ready[i] && n < 50) begin
            @(negedge ACLK);
            #1;
            n++;
        end
        chk("req_accept", req_ready[i], 1'b1);
        @(negedge ACLK);
        req_valid[i] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        chk("drain", sb.size(), 0);
        repeat (2) @(negedge ACLK);
    endtask

    initial begin
        int n;
        int r0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr = '0;
        req_wdata = '0;
        #1 ARESETN = 1'b0;
        repeat (2) @(negedge ACLK);
        req_valid = 2'b11;
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_wvalid", wvalid, 0);
        chk("rst_bready", bready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp", rsp_resp, 0);
        req_valid = 2'b00;
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);

        // Round-robin with both reads held: first tie goes to requester 0
        req_addr = 8'h84;
        req_write = 2'b00;
        req_valid = 2'b11;
        n = 0;
        while (grant_log.size() < 4 && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        req_valid = 2'b00;
        drain();
        chk("rr_count", grant_log.size(), 4);
        chk("rr_g0", grant_log[0], 0);
        chk("rr_g1", grant_log[1], 1);
        chk("rr_g2", grant_log[2], 0);
        chk("rr_g3", grant_log[3], 1);
        chk("rr_a0", ar_log[0], 4'h4);
        chk("rr_a1", ar_log[1], 4'h8);
        chk("rr_a2", ar_log[2], 4'h4);
        chk("rr_a3", ar_log[3], 4'h8);

        // Write then read back through requester 0
        aw_log.delete();
        w_log.delete();
        req(0, 1'b1, 4'h0, 32'h0000_0001);
        req(0, 1'b0, 4'h0, 32'h0);
        drain();
        chk("wr_aw_count", aw_log.size(), 1);
        chk("wr_awaddr", aw_log[0], 4'h0);
        chk("wr_w_count", w_log.size(), 1);
        chk("wr_wstrb_wdata", w_log[0], {4'hF, 32'h0000_0001});

        // WREADY held off 3 cycles behind AWREADY
        w_delay = 3;
        aw_cyc = 0;
        w_cyc = 0;
        r0 = rsp_cnt;
        req(1, 1'b1, 4'hC, 32'hDEAD_BEEF);
        drain();
        w_delay = 0;
        chk("slow_w_awvalid_cycles", aw_cyc, 1);
        chk("slow_w_wvalid_cycles", w_cyc, 4);
        chk("slow_w_rsp_count", rsp_cnt - r0, 1);

        // Back-to-back writes from requester 1 against a zero-wait slave
        acc_cyc1.delete();
        req(1, 1'b1, 4'h4, 32'hCAFE_0004);
        req(1, 1'b1, 4'h8, 32'hCAFE_0008);
        drain();
        chk("b2b_count", acc_cyc1.size(), 2);
        chk("b2b_spacing", acc_cyc1[1] - acc_cyc1[0], 4);

        // SLVERR on a read passes through with the slave's data
        rerr = 1'b1;
        req(0, 1'b0, 4'h4, 32'h0);
        drain();
        rerr = 1'b0;

        // Reset while waiting in RD_DATA aborts the read
        r_stall = 1'b1;
        r0 = rsp_cnt;
        req(0, 1'b0, 4'h8, 32'h0);
        n = 0;
        while (!rready && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        chk("abort_in_rd_data", rready, 1'b1);
        ARESETN = 1'b0;
        #1;
        chk("abort_rready", rready, 0);
        chk("abort_arvalid", arvalid, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        sb.delete();
        repeat (2) @(negedge ACLK);
        r_stall = 1'b0;
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("abort_no_rsp", rsp_cnt - r0, 0);
        req(1, 1'b0, 4'hC, 32'h0);
        drain();
        chk("after_abort_rsp", rsp_cnt - r0, 1);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
